// File: rtl/mult_seq_module_if.sv
// Request/response bundle shared by the sequential multiplier and its requester.
// The master side issues ctrl_MULT with its operands. The slave side (the
// multiplier) returns the registered product, the overflow flag and the
// ready strobes.
interface mult_seq_module_if #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 16
);
  logic               ctrl_MULT;
  logic [WIDTH_A-1:0] data_operandA;
  logic [WIDTH_B-1:0] data_operandB;
  logic [WIDTH_A-1:0] data_result;
  logic               data_exception;
  logic               data_inputRDY;
  logic               data_resultRDY;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_inputRDY, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_inputRDY, data_resultRDY
  );
endinterface

// File: rtl/mult_seq_module.sv
// Sequential signed multiplier using radix-2 shift-add on operand magnitudes.
// It processes one multiplier bit per clock and re-applies the sign at the end.
// It returns the low WIDTH_A bits of the product and flags results that do not
// fit in WIDTH_A signed bits.
// Optional build macro MULT_EARLY_TERM_EN: RUN also finishes as soon as the
// remaining multiplier bits are all zero, so latency is 1..WIDTH_B iterations.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT, inputRDY=1
// RUN   | shift-add iterations in progress, inputRDY=0
// DONE  | result valid this cycle (resultRDY pulse), new request may be accepted
module mult_seq_module #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 16
) (
  input  logic              clock,
  input  logic              reset,
  mult_seq_module_if.slave  bus
);
  localparam int ACC_W = WIDTH_A + WIDTH_B;
  localparam int CNT_W = $clog2(WIDTH_B + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [ACC_W-1:0]   mcand;
  logic [WIDTH_B-1:0] mplier;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               sign_q;
  logic [WIDTH_A-1:0] res_q;
  logic               exc_q;
  logic               in_rdy_q;
  logic               res_rdy_q;

  logic [WIDTH_A-1:0]      a_mag;
  logic [WIDTH_B-1:0]      b_mag;
  logic [ACC_W-1:0]        acc_sum;
  logic [WIDTH_B-1:0]      mplier_sh;
  logic signed [ACC_W:0]   prod;
  logic [ACC_W-WIDTH_A+1:0] prod_top;
  logic                    prod_ovf;
  logic                    last_iter;

  // Operand magnitudes, next accumulator and the signed product of the final iteration.
  // The most negative operand value maps onto its own bit pattern, which is
  // still the correct unsigned magnitude.
  always_comb begin
    a_mag     = bus.data_operandA[WIDTH_A-1] ? -bus.data_operandA : bus.data_operandA;
    b_mag     = bus.data_operandB[WIDTH_B-1] ? -bus.data_operandB : bus.data_operandB;
    acc_sum   = acc + (mplier[0] ? mcand : '0);
    mplier_sh = mplier >> 1;
    prod      = sign_q ? -$signed({1'b0, acc_sum}) : $signed({1'b0, acc_sum});
    prod_top  = prod[ACC_W:WIDTH_A-1];
    prod_ovf  = ~((&prod_top) | ~(|prod_top));
`ifdef MULT_EARLY_TERM_EN
    last_iter = (cnt == CNT_W'(WIDTH_B - 1)) || (mplier_sh == '0);
`else
    last_iter = (cnt == CNT_W'(WIDTH_B - 1));
`endif
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      in_rdy_q  <= 1'b1;
      res_rdy_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          res_rdy_q <= 1'b0;
          if (bus.ctrl_MULT) begin
            mcand    <= {{WIDTH_B{1'b0}}, a_mag};
            mplier   <= b_mag;
            sign_q   <= bus.data_operandA[WIDTH_A-1] ^ bus.data_operandB[WIDTH_B-1];
            acc      <= '0;
            cnt      <= '0;
            in_rdy_q <= 1'b0;
            state    <= RUN;
          end else begin
            in_rdy_q <= 1'b1;
            state    <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            res_q     <= prod[WIDTH_A-1:0];
            exc_q     <= prod_ovf;
            in_rdy_q  <= 1'b1;
            res_rdy_q <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          in_rdy_q  <= 1'b1;
          res_rdy_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_inputRDY  = in_rdy_q;
  assign bus.data_resultRDY = res_rdy_q;
endmodule

// File: tb/tb_mult_seq_module.sv
// Scoreboard bench for the sequential multiplier. The stimulus process pushes
// hand-computed products. The monitor pops one product and compares it on every
// resultRDY pulse.
module tb_mult_seq_module;
  logic clock;
  logic reset;

  mult_seq_module_if bus ();

  mult_seq_module dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected iteration count: fixed, or the bit length of |B| when early termination is built in.
  function automatic int exp_lat(input logic [15:0] b);
    logic [15:0] m;
    int n;
    m = b[15] ? -b : b;
    n = 1;
    for (int i = 0; i < 16; i++) if (m[i]) n = i + 1;
`ifndef MULT_EARLY_TERM_EN
    n = 16;
`endif
    return n;
  endfunction

  // Monitor: every resultRDY pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse result=%h exc=%0b required no pulse",
                   bus.data_result, bus.data_exception);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (bus.data_result !== e.res) begin
            errors++;
            $display("FAIL result got=%h required=%h", bus.data_result, e.res);
          end
          checks++;
          if (bus.data_exception !== e.exc) begin
            errors++;
            $display("FAIL exception got=%0b required=%0b (result %h)",
                     bus.data_exception, e.exc, e.res);
          end
        end
      end
    end
  end

  task automatic wait_rdy();
    int i;
    for (i = 0; i < 60 && !bus.data_inputRDY; i++) @(negedge clock);
    if (!bus.data_inputRDY) begin
      $display("FAIL inputRDY_timeout got=0 required=1");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "inputRDY never returned");
    end
  endtask

  // Called at the negedge right after acceptance; returns at the negedge showing resultRDY.
  task automatic wait_done(input int lat_req, input string name);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.data_resultRDY) seen = 1;
      else begin
        if (!bus.data_inputRDY) lat++;
        @(negedge clock);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout got=no resultRDY required=pulse", name);
    end else if (lat != lat_req) begin
      errors++;
      $display("FAIL %s_latency got=%0d required=%0d", name, lat, lat_req);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                        input logic [31:0] er, input logic ee, input string name);
    exp_q.push_back('{res: er, exc: ee});
    wait_rdy();
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = ~a;
    bus.data_operandB = ~b;
    wait_done(exp_lat(b), name);
    @(negedge clock);
  endtask

  initial begin
    int busy;
    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd5;
    bus.data_operandB = 16'd5;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.data_inputRDY !== 1'b1 || bus.data_resultRDY !== 1'b0 ||
        bus.data_result !== 32'h0 || bus.data_exception !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got=rdy%0b/%0b res=%h exc=%0b required=rdy1/0 res=0 exc=0",
               bus.data_inputRDY, bus.data_resultRDY, bus.data_result, bus.data_exception);
    end
    bus.ctrl_MULT = 1'b0;
    reset         = 1'b0;
    @(negedge clock);

    run_op(32'd7,        16'd6,    32'h0000002A, 1'b0, "pos_pos");
    run_op(32'hFFFFFFFB, 16'h0003, 32'hFFFFFFF1, 1'b0, "neg_pos");
    run_op(32'hFFFFFFFB, 16'hFFFD, 32'h0000000F, 1'b0, "neg_neg");
    run_op(32'h80000000, 16'h0001, 32'h80000000, 1'b0, "min_one");
    run_op(32'h80000000, 16'hFFFF, 32'h80000000, 1'b1, "min_mone");
    run_op(32'h00010000, 16'h0100, 32'h01000000, 1'b0, "fit_big");
    run_op(32'h00100000, 16'h1000, 32'h00000000, 1'b1, "ovf_2p32");
    run_op(32'h00000000, 16'hF234, 32'h00000000, 1'b0, "zero_a");
    run_op(32'h12345678, 16'h0000, 32'h00000000, 1'b0, "zero_b");
    run_op(32'hFFFFFFFF, 16'h8000, 32'h00008000, 1'b0, "mone_minb");
    run_op(32'h7FFFFFFF, 16'h7FFF, 32'h7FFF8001, 1'b1, "max_max");
    run_op(32'd4,        16'd1,    32'h00000004, 1'b0, "b_one");

    // Back-to-back: ctrl_MULT held high through RUN and into the DONE cycle.
    exp_q.push_back('{res: 32'h10, exc: 1'b0});
    exp_q.push_back('{res: 32'h0A, exc: 1'b0});
    wait_rdy();
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd4;
    bus.data_operandB = 16'd4;
    @(negedge clock);
    bus.data_operandA = 32'd2;
    bus.data_operandB = 16'd5;
    wait_done(exp_lat(16'd4), "b2b_first");
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    wait_done(exp_lat(16'd5), "b2b_second");
    @(negedge clock);

    // Reset during RUN aborts the operation and the ignored mid-RUN request.
    wait_rdy();
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd3;
    bus.data_operandB = 16'd3;
    @(negedge clock);
    bus.data_operandA = 32'd9;
    bus.data_operandB = 16'd9;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (bus.data_inputRDY !== 1'b1 || bus.data_resultRDY !== 1'b0 ||
        bus.data_result !== 32'h0 || bus.data_exception !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got=rdy%0b/%0b res=%h exc=%0b required=rdy1/0 res=0 exc=0",
               bus.data_inputRDY, bus.data_resultRDY, bus.data_result, bus.data_exception);
    end
    busy = 0;
    repeat (30) begin
      @(negedge clock);
      if (!bus.data_inputRDY) busy++;
    end
    checks++;
    if (busy != 0) begin
      errors++;
      $display("FAIL abort_idle busy_cycles got=%0d required=0", busy);
    end

    run_op(32'hFFFFFFFE, 16'h0005, 32'hFFFFFFF6, 1'b0, "after_abort");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
